alu_mul_result_sequencer: RTL and testbench

- Sequential front/back-end wrapped around the combinational signed 32x32->64 multiplier in the ALU datapath.
- Accepts operand pairs over a valid/ready handshake and holds them registered on the multiplier inputs.
- Captures the 64-bit signed product and returns it on a 32-bit result bus: low word, high word, or both in two beats, selected per operation.
- Flags when the product does not fit in 32 signed bits.

---
 rtl/alu_mul_result_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_mul_result_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_result_sequencer.sv
// Registers operand pairs onto an external signed WIDTHxWIDTH multiplier, captures the
// 2*WIDTH product and returns it as low word, high word, or both, with a signed-overflow flag.
module alu_mul_result_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_mode,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               out_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CALC    = 2'b01,
        ST_SEND_LO = 2'b10,
        ST_SEND_HI = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_MULH = 2'b01,
        MODE_MULW = 2'b10
    } mode_t;

    state_t               state_q;
    mode_t                mode_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 ovf_q;
    logic                 hi_sel_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 busy_q;

    // The product fits in WIDTH signed bits only if its top WIDTH+1 bits are all equal.
    logic [WIDTH:0]       prod_top;
    logic                 prod_ovf;

    assign prod_top = mul_product[2*WIDTH-1:WIDTH-1];
    assign prod_ovf = !((&prod_top) || (~|prod_top));

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make ordering inside the block matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, so out_data reads zero and the
            // multiplier sees zero operands straight out of reset.
            state_q     <= ST_IDLE;
            mode_q      <= MODE_MUL;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            prod_q      <= '0;
            ovf_q       <= 1'b0;
            hi_sel_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a_q    <= in_a;
                        mul_b_q    <= in_b;
                        mode_q     <= (in_mode == 2'b11) ? MODE_MUL : mode_t'(in_mode);
                        state_q    <= ST_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                ST_CALC: begin
                    prod_q      <= mul_product;
                    ovf_q       <= prod_ovf;
                    out_valid_q <= 1'b1;
                    if (mode_q == MODE_MULH) begin
                        state_q    <= ST_SEND_HI;
                        hi_sel_q   <= 1'b1;
                        out_last_q <= 1'b1;
                    end else begin
                        state_q    <= ST_SEND_LO;
                        hi_sel_q   <= 1'b0;
                        out_last_q <= (mode_q != MODE_MULW);
                    end
                end

                ST_SEND_LO: begin
                    if (out_ready) begin
                        if (mode_q == MODE_MULW) begin
                            state_q    <= ST_SEND_HI;
                            hi_sel_q   <= 1'b1;
                            out_last_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            hi_sel_q    <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end

                ST_SEND_HI: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        hi_sel_q    <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Word selection is a mux over registers only; nothing from mul_product or in_* reaches out_*.
    assign out_data  = out_valid_q ? (hi_sel_q ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0])
                                   : '0;
    assign out_ovf   = out_valid_q & ovf_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_alu_mul_result_sequencer.sv
// Scoreboard bench for alu_mul_result_sequencer: directed operations push expected beats,
// a negedge monitor pops and compares every accepted result word.
module tb_alu_mul_result_sequencer;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         ovf;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [1:0]     in_mode = '0;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_product;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ovf;
    logic           busy;

    int    chk_cnt = 0;
    int    pass_cnt = 0;
    int    cyc = 0;
    beat_t exp_q[$];

    alu_mul_result_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_product(mul_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    // Combinational signed multiplier the block sits around.
    assign mul_product = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_beat(input logic [W-1:0] data, input logic last, input logic ovf);
        beat_t b;
        b.data = data;
        b.last = last;
        b.ovf  = ovf;
        exp_q.push_back(b);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode);
        bit ok;
        ok = 0;
        in_a = a;
        in_b = b;
        in_mode = mode;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("out_valid_timeout", 64'(out_valid), 1);
    endtask

    // Monitor: a beat transfers at the next posedge when valid and ready are both high here.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            check("beat_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(b.data));
                check("out_last", 64'(out_last), 64'(b.last));
                check("out_ovf",  64'(out_ovf),  64'(b.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int acc[3];
        bit ok;

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data",  64'(out_data),  0);
        check("rst_out_last",  64'(out_last),  0);
        check("rst_out_ovf",   64'(out_ovf),   0);
        check("rst_busy",      64'(busy),      0);
        check("rst_mul_a",     64'(mul_a),     0);
        check("rst_mul_b",     64'(mul_b),     0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        // Mode 00: 3 * -5 = -15, with latency measurement
        expect_beat(32'hFFFF_FFF1, 1'b1, 1'b0);
        issue(32'd3, 32'hFFFF_FFFB, 2'b00);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency_cycles", 64'(lat), 2);
        check("mul_a_captured", 64'(mul_a), 64'(32'd3));
        check("mul_b_captured", 64'(mul_b), 64'(32'hFFFF_FFFB));
        wait_idle();
        check("mul_a_held_idle", 64'(mul_a), 64'(32'd3));
        check("busy_idle", 64'(busy), 0);

        // Mode 01: 2^30 * 2^30 = 2^60
        expect_beat(32'h1000_0000, 1'b1, 1'b1);
        issue(32'h4000_0000, 32'h4000_0000, 2'b01);
        wait_idle();

        // Mode 10: 0x7FFFFFFF * 2 = 0x00000000_FFFFFFFE, overflows 32 signed bits
        expect_beat(32'hFFFF_FFFE, 1'b0, 1'b1);
        expect_beat(32'h0000_0000, 1'b1, 1'b1);
        issue(32'h7FFF_FFFF, 32'd2, 2'b10);
        wait_idle();

        // Mode 11 runs as 00: -2 * 3 = -6
        expect_beat(32'hFFFF_FFFA, 1'b1, 1'b0);
        issue(32'hFFFF_FFFE, 32'd3, 2'b11);
        wait_idle();

        // Backpressure, mode 10: -7 * 6 = -42, with an ignored offer during the stall
        out_ready = 1'b0;
        expect_beat(32'hFFFF_FFD6, 1'b0, 1'b0);
        expect_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(32'hFFFF_FFF9, 32'd6, 2'b10);
        wait_out_valid();
        in_a = 32'd9;
        in_b = 32'd9;
        in_mode = 2'b00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 1);
            check("bp_out_data",  64'(out_data),  64'(32'hFFFF_FFD6));
            check("bp_out_last",  64'(out_last),  0);
            check("bp_in_ready",  64'(in_ready),  0);
            check("bp_busy",      64'(busy),      1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset in SEND_LO of a mode 10 op: 5 * 5
        out_ready = 1'b0;
        expect_beat(32'h0000_0019, 1'b0, 1'b0);
        expect_beat(32'h0000_0000, 1'b1, 1'b0);
        issue(32'd5, 32'd5, 2'b10);
        wait_out_valid();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_out_data",  64'(out_data),  0);
        check("midrst_busy",      64'(busy),      0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 1);
        check("midrst_mul_a",    64'(mul_a),    0);
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) ok = 0;
        end
        check("midrst_no_stale", 64'(ok), 1);
        @(posedge clk);
        #1;
        expect_beat(32'd16, 1'b1, 1'b0);
        issue(32'd4, 32'd4, 2'b00);
        wait_idle();

        // Back-to-back mode 00 with in_valid held high
        expect_beat(32'd1, 1'b1, 1'b0);
        expect_beat(32'd4, 1'b1, 1'b0);
        expect_beat(32'd9, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            in_a = 32'(k + 1);
            in_b = 32'(k + 1);
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) check("b2b_accept_timeout", 64'(in_ready), 1);
            @(posedge clk);
            #1;
            acc[k] = cyc;
        end
        in_valid = 1'b0;
        check("b2b_spacing_1", 64'(acc[1] - acc[0]), 3);
        check("b2b_spacing_2", 64'(acc[2] - acc[1]), 3);
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
